fetch_seq_ctrl: RTL
===================

# fetch_seq_ctrl

Multi-cycle sequencer for the fetch stage. It issues instruction-memory requests, latches the returned instruction, and holds it for decode. Once decode has resolved the next-PC selection, it applies that selection to the PC register in a single write-enabled cycle. It sits between the instruction memory, the decoder/hazard logic and the PC register, and is the only block that drives `pc_src` and `pc_we`.

## Interface
- `W_CPU`, 32: instruction/data width.
- `W_PC_SRC`, 2: width of the PC source select; encodings are the codebase `PC_SRC_NEXT`/`PC_SRC_REGF`/`PC_SRC_JUMP`/`PC_SRC_BRCH` macros.
- `TIMEOUT`, 16: maximum cycles spent in FETCH without `imem_ack` before a fetch error; legal range 1..255.

Ports:
- `clk` in 1: the single clock; everything is rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `imem_req` out 1: instruction read request.
- `imem_ack` in 1: read data valid this cycle.
- `imem_rdata` in W_CPU: instruction word.
- `ir` out W_CPU: latched instruction.
- `instr_valid` out 1: one-cycle pulse; `ir` is new and decode outputs must be valid this cycle.
- `dec_pc_src` in W_PC_SRC: next-PC selection decoded from `ir`.
- `dec_halt` in 1: `ir` is a halt/syscall.
- `stall` in 1: hazard or busy downstream; blocks the PC update.
- `pc_src` out W_PC_SRC: registered selection to the PC register.
- `pc_we` out 1: PC register update enable, one cycle per instruction.
- `halted` out 1: the sequencer has stopped.
- `fetch_err` out 1: the fetch timed out; sticky until reset.
- `cnt_instr` out 32: retired instructions (present only with `FETCH_SEQ_PERF_EN`).
- `cnt_stall` out 32: stall cycles (present only with `FETCH_SEQ_PERF_EN`).

## Operation
FSM states are IDLE, FETCH, DECODE, STALL, UPDATE and HALT.
- **IDLE:** entered on reset. Moves to FETCH on the next clock.
- **FETCH:** `imem_req`=1.
  - On `imem_ack`: `ir`<=`imem_rdata` and go to DECODE.
  - Otherwise increment the 8-bit wait counter. When the counter reaches `TIMEOUT`, set `fetch_err`=1 and go to HALT.
- **DECODE:** `instr_valid`=1. Sample `dec_halt`, `dec_pc_src` and `stall` in this cycle.
  - `dec_halt`=1 → HALT. `dec_halt` has priority over `stall`.
  - Otherwise `pc_src`<=`dec_pc_src`.
  - Then `stall`=1 → STALL, else → UPDATE.
- **STALL:** hold `pc_src`. Go to UPDATE in the cycle after `stall` is sampled 0.
- **UPDATE:** `pc_we`=1 for exactly this cycle. Go to FETCH and clear the wait counter.
- **HALT:** `halted`=1 and `imem_req`=0. Only reset exits this state.

Rules:
- An unencoded `dec_pc_src` value is latched as `PC_SRC_NEXT`.
- `imem_ack` outside FETCH is ignored; `ir` does not change.
- `imem_req` is never withdrawn in FETCH before `imem_ack` or timeout.
- `ir` and `pc_src` are held stable from capture until the next capture.
- Reset asserted in any state, including mid-FETCH or STALL, forces IDLE and all reset values at once. A pending memory response is discarded.

## Timing
- Reset values: `imem_req`=0, `ir`=0, `instr_valid`=0, `pc_src`=`PC_SRC_NEXT`, `pc_we`=0, `halted`=0, `fetch_err`=0, counters=0, state=IDLE.
- `imem_req` rises 1 cycle after reset release, on entry to FETCH.
- Instruction period is 3 + (ack wait cycles) + (stall cycles), with a minimum of 3: FETCH with same-cycle ack, then DECODE, then UPDATE.
- `pc_we` asserts in the cycle after DECODE when unstalled. The PC register shows the new value the cycle after `pc_we`.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- `FETCH_SEQ_PERF_EN` defined: `cnt_instr` and `cnt_stall` ports are present.
  - `cnt_instr` increments on every `pc_we` cycle.
  - `cnt_stall` increments on every cycle spent in STALL.
  - Both wrap modulo 2^32 and reset to 0.
- `FETCH_SEQ_PERF_EN` undefined: ports and counters are absent. All other behaviour is identical.

## Test plan
- **Basic sequence:** release reset with `imem_ack` tied high, `dec_pc_src`=`PC_SRC_NEXT`, `stall`=0 → `imem_req` at cycle 1, `instr_valid` at cycle 2, `pc_we` at cycle 3, repeating every 3 cycles; `ir` equals `imem_rdata` at each ack.
- **Memory wait and stall:** delay ack 5 cycles, then hold `stall`=1 for 4 cycles after DECODE → period is 12 cycles; `pc_we` rises once; `cnt_stall`=4 (with macro).
- **Branch capture:** present `dec_pc_src`=`PC_SRC_BRCH` only in the DECODE cycle and change it during STALL → `pc_src`=`PC_SRC_BRCH` throughout STALL and UPDATE.
- **Halt and timeout:** `dec_halt`=1 together with `stall`=1 → HALT, `halted`=1, `pc_we` never asserts, `imem_req`=0 thereafter. Separately, with `TIMEOUT`=16 and no ack → `fetch_err`=1 after the 16th FETCH wait cycle.
- **Reset mid-operation:** assert `rst` mid-STALL and mid-FETCH → all outputs return to reset values in the same cycle; after release the sequence restarts from IDLE; an ack arriving during reset is not latched into `ir`.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: multi-cycle fetch-stage sequencer.
// Issues instruction-memory reads, latches the returned word into ir, holds it
// for decode, then applies the decoded next-PC selection in a one-cycle
// pc_we window. A fetch that waits too long for imem_ack stops the sequencer
// with a sticky fetch_err.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   imem_req          instruction read request (out)
//   imem_ack          read data valid this cycle (in)
//   imem_rdata        instruction word (in)
//   ir                latched instruction (out)
//   instr_valid       one-cycle pulse, ir is new and decode inputs are sampled (out)
//   dec_pc_src        next-PC selection decoded from ir (in)
//   dec_halt          ir is a halt/syscall (in)
//   stall             hazard/busy, blocks the PC update (in)
//   pc_src            registered selection to the PC register (out)
//   pc_we             PC register write enable, one cycle per instruction (out)
//   halted            sequencer has stopped (out)
//   fetch_err         fetch timed out, sticky until reset (out)
//   cnt_instr         retired instruction count (out, FETCH_SEQ_PERF_EN only)
//   cnt_stall         stall cycle count (out, FETCH_SEQ_PERF_EN only)
//
// Optional feature macro: FETCH_SEQ_PERF_EN adds the performance counters.
// Every output is a flop; next values are decoded from the next state so the
// outputs change on entry to a state and never follow an input combinationally.

`ifndef PC_SRC_NEXT
`define PC_SRC_NEXT 2'd0
`endif
`ifndef PC_SRC_REGF
`define PC_SRC_REGF 2'd1
`endif
`ifndef PC_SRC_JUMP
`define PC_SRC_JUMP 2'd2
`endif
`ifndef PC_SRC_BRCH
`define PC_SRC_BRCH 2'd3
`endif

module fetch_seq_ctrl #(
   parameter int unsigned W_CPU    = 32,
   parameter int unsigned W_PC_SRC = 2,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   input  logic                imem_ack,
   input  logic [W_CPU-1:0]    imem_rdata,
   output logic [W_CPU-1:0]    ir,
   output logic                instr_valid,
   input  logic [W_PC_SRC-1:0] dec_pc_src,
   input  logic                dec_halt,
   input  logic                stall,
   output logic [W_PC_SRC-1:0] pc_src,
   output logic                pc_we,
   output logic                halted,
   output logic                fetch_err
`ifdef FETCH_SEQ_PERF_EN
   ,
   output logic [31:0]         cnt_instr,
   output logic [31:0]         cnt_stall
`endif
);

   localparam int unsigned W_WAIT = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_STALL,
      S_UPDATE,
      S_HALT
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [W_WAIT-1:0]   wait_cnt;
   logic [W_WAIT-1:0]   wait_nxt;
   logic [W_CPU-1:0]    ir_nxt;
   logic [W_PC_SRC-1:0] pc_src_nxt;
   logic [W_PC_SRC-1:0] src_legal;
   logic                fetch_err_nxt;
   logic                imem_req_nxt;
   logic                instr_valid_nxt;
   logic                pc_we_nxt;
   logic                halted_nxt;
   logic                wait_expired;

   // Unencoded selections fall back to the sequential next PC.
   always_comb begin
      src_legal = W_PC_SRC'(`PC_SRC_NEXT);
      case (dec_pc_src)
         W_PC_SRC'(`PC_SRC_NEXT),
         W_PC_SRC'(`PC_SRC_REGF),
         W_PC_SRC'(`PC_SRC_JUMP),
         W_PC_SRC'(`PC_SRC_BRCH): src_legal = dec_pc_src;
         default:                 src_legal = W_PC_SRC'(`PC_SRC_NEXT);
      endcase
   end

   // This FETCH cycle is the TIMEOUT-th one without an ack.
   assign wait_expired = ((9'(wait_cnt) + 9'd1) == 9'(TIMEOUT));

   // State register plus the registered outputs and datapath holding regs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         ir          <= '0;
         pc_src      <= W_PC_SRC'(`PC_SRC_NEXT);
         fetch_err   <= 1'b0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         pc_we       <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_nxt;
         ir          <= ir_nxt;
         pc_src      <= pc_src_nxt;
         fetch_err   <= fetch_err_nxt;
         imem_req    <= imem_req_nxt;
         instr_valid <= instr_valid_nxt;
         pc_we       <= pc_we_nxt;
         halted      <= halted_nxt;
      end
   end

   // Next-state logic; halt wins over stall in DECODE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   state_nxt = S_FETCH;
         S_FETCH: begin
            if (imem_ack)          state_nxt = S_DECODE;
            else if (wait_expired) state_nxt = S_HALT;
         end
         S_DECODE: begin
            if (dec_halt)   state_nxt = S_HALT;
            else if (stall) state_nxt = S_STALL;
            else            state_nxt = S_UPDATE;
         end
         S_STALL:  if (!stall) state_nxt = S_UPDATE;
         S_UPDATE: state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and holding registers.
   always_comb begin
      wait_nxt        = wait_cnt;
      ir_nxt          = ir;
      pc_src_nxt      = pc_src;
      fetch_err_nxt   = fetch_err;
      imem_req_nxt    = (state_nxt == S_FETCH);
      instr_valid_nxt = (state_nxt == S_DECODE);
      pc_we_nxt       = (state_nxt == S_UPDATE);
      halted_nxt      = (state_nxt == S_HALT);
      case (state)
         S_FETCH: begin
            if (imem_ack) begin
               ir_nxt = imem_rdata;
            end else begin
               wait_nxt = wait_cnt + W_WAIT'(1);
               if (wait_expired) fetch_err_nxt = 1'b1;
            end
         end
         S_DECODE: if (!dec_halt) pc_src_nxt = src_legal;
         S_UPDATE: wait_nxt = '0;
         default:  ;
      endcase
   end

`ifdef FETCH_SEQ_PERF_EN
   // Free-running performance counters, wrapping modulo 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_instr <= '0;
         cnt_stall <= '0;
      end else begin
         cnt_instr <= cnt_instr + 32'(pc_we);
         cnt_stall <= cnt_stall + 32'(state == S_STALL);
      end
   end
`endif

endmodule
